pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; legal values are multiples of SEG, from 8 to 64.
REQ-002 SHALL have parameter SEG, default 4, ripple segment width in bits; one pipeline stage per segment.
REQ-003 SHALL derive localparam STAGES = WIDTH/SEG, which is both the pipeline depth and the latency.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, operand beat present.
REQ-007 SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-008 SHALL have port a, input, WIDTH, operand A.
REQ-009 SHALL have port b, input, WIDTH, operand B.
REQ-010 SHALL have port cin, input, 1, carry-in; acts as borrow-in when sub=1.
REQ-011 SHALL have port sub, input, 1, mode select: 0 = add, 1 = subtract.
REQ-012 SHALL have port out_valid, output, 1, result present.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-014 SHALL have port sum, output, WIDTH, result.
REQ-015 SHALL have port cout, output, 1, carry-out; when sub=1, 1 means no borrow.
REQ-016 SHALL have port ovf, output, 1, signed overflow.

Function
REQ-017 SHALL compute, for sub=0: {cout,sum} = a + b + cin.
REQ-018 SHALL compute, for sub=1: {cout,sum} = a + ~b + !cin, i.e. a - b - cin in two's complement.
REQ-019 SHALL set ovf = carry into bit WIDTH-1 XOR cout.
REQ-020 SHALL, in stage k (k=0..STAGES-1), add segment k of a and segment k of the conditioned b, plus the carry registered from stage k-1; stage 0 uses the conditioned cin.
REQ-021 SHALL register the stage k sum segment and carry, and carry the unconsumed upper operand bits forward skewed, so each beat's segments stay aligned.
REQ-022 SHALL accept a beat on in_valid & in_ready and present its result on out_valid exactly STAGES cycles later when no backpressure occurs.
REQ-023 SHALL hold a per-stage valid bit, and stage k SHALL advance when stage k is empty or stage k+1 advances; the last stage advances on out_ready.
REQ-024 SHALL drive in_ready = !valid[0] | advance[0], so full throughput of 1 beat per cycle is sustained while out_ready=1.
REQ-025 SHALL hold sum, cout and ovf stable while out_valid=1 and out_ready=0.
REQ-026 SHALL NOT drop, duplicate or reorder beats under any in_valid/out_ready pattern.
REQ-027 SHALL, with the pipe full and out_ready=0, deassert in_ready in the same cycle.
REQ-028 SHALL, on a simultaneous accept and emit with the pipe full, accept the new beat in that cycle.
REQ-029 SHALL, on arithmetic wrap-around (for example all-ones + 1), produce sum=0 and cout=1 with no special handling.
REQ-030 SHALL apply the sub mode per beat; mixed add and subtract beats in flight SHALL be independent.

Reset
REQ-031 SHALL, while rst_n=0, clear all stage valid bits immediately; out_valid=0, sum=0, cout=0, ovf=0, and in_ready=1 after release.
REQ-032 SHALL discard beats in flight on reset assertion mid-operation; no result for them appears after release.
REQ-033 SHALL allow datapath registers other than those driving the outputs to be non-reset.

Structure
REQ-034 SHALL place default WIDTH/SEG constants and the STAGES derivation function in shared package adder_pkg.
REQ-035 SHALL use one combinational sub-module adder_seg: SEG-bit ripple of full-adder cells, with cin, sum and cout, instantiated STAGES times via generate.

Verification
REQ-036 SHALL cover: WIDTH=16, SEG=4, a=0x1234, b=0x0FFF, cin=1, sub=0 -> after 4 cycles sum=0x2234, cout=0, ovf=0.
REQ-037 SHALL cover: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0.
REQ-038 SHALL cover: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1; and a=0x0003, b=0x0005, cin=0, sub=1 -> sum=0xFFFE, cout=0.
REQ-039 SHALL cover: 20 back-to-back beats with out_ready=1 -> 20 results in order, one per cycle, starting at cycle 4.
REQ-040 SHALL cover: pipe full with out_ready=0 for 6 cycles -> in_ready=0, outputs held; on release, results drain in order with no loss.
REQ-041 SHALL cover: rst_n pulsed low with 3 beats in flight -> out_valid=0 immediately, and no stale result after release.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
package adder_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultSeg   = 4;

    function automatic int unsigned stage_count(input int unsigned width, input int unsigned seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/adder_seg.sv
// SEG-bit ripple-carry adder built from full-adder cells; purely combinational.
module adder_seg #(
    parameter int unsigned SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    logic [SEG:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < SEG; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[SEG];
    end

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract unit pipelined one SEG-bit ripple segment per stage, with a
// valid/ready handshake that sustains one beat per cycle.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned SEG   = DefaultSeg
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = stage_count(WIDTH, SEG);
    localparam int unsigned LAST   = STAGES - 1;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;

    // A stage may move when it is empty or its successor is moving too.
    always_comb begin
        adv       = '0;
        adv[LAST] = ~valid_q[LAST] | out_ready;
        for (int k = int'(LAST) - 1; k >= 0; k--) begin
            adv[k] = ~valid_q[k] | adv[k+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (adv[0]) begin
                valid_q[0] <= in_valid;
            end
            for (int k = 1; k < int'(STAGES); k++) begin
                if (adv[k]) begin
                    valid_q[k] <= valid_q[k-1];
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits not yet consumed by earlier stages.
        localparam int unsigned REM = WIDTH - k * SEG;

        logic [REM-1:0]       a_rem;
        logic [REM-1:0]       b_rem;
        logic                 c_in;
        logic                 src_valid;
        logic [SEG-1:0]       seg_sum;
        logic                 seg_cout;
        logic [(k+1)*SEG-1:0] sum_nxt;

        if (k == 0) begin : g_src
            assign a_rem     = a;
            assign b_rem     = b ^ {WIDTH{sub}};
            assign c_in      = cin ^ sub;
            assign src_valid = in_valid;
            assign sum_nxt   = seg_sum;
        end else begin : g_src
            assign a_rem     = g_stage[k-1].g_reg.a_hi_q;
            assign b_rem     = g_stage[k-1].g_reg.b_hi_q;
            assign c_in      = g_stage[k-1].g_reg.carry_q;
            assign src_valid = valid_q[k-1];
            assign sum_nxt   = {seg_sum, g_stage[k-1].g_reg.sum_lo_q};
        end

        adder_seg #(
            .SEG(SEG)
        ) u_seg (
            .a   (a_rem[SEG-1:0]),
            .b   (b_rem[SEG-1:0]),
            .cin (c_in),
            .sum (seg_sum),
            .cout(seg_cout)
        );

        if (k != LAST) begin : g_reg
            logic [REM-SEG-1:0]   a_hi_q;
            logic [REM-SEG-1:0]   b_hi_q;
            logic [(k+1)*SEG-1:0] sum_lo_q;
            logic                 carry_q;

            // Interior datapath needs no reset: valid_q qualifies it.
            always_ff @(posedge clk) begin
                if (adv[k] && src_valid) begin
                    a_hi_q   <= a_rem[REM-1:SEG];
                    b_hi_q   <= b_rem[REM-1:SEG];
                    sum_lo_q <= sum_nxt;
                    carry_q  <= seg_cout;
                end
            end
        end else begin : g_out
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end else if (adv[k] && src_valid) begin
                    sum_q  <= sum_nxt;
                    cout_q <= seg_cout;
                    // a^b^s at the MSB recovers the carry into the MSB.
                    ovf_q  <= a_rem[SEG-1] ^ b_rem[SEG-1] ^ seg_sum[SEG-1] ^ seg_cout;
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[LAST];
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vector table plus stream,
// backpressure and mid-flight reset sequences, scored against a queue.
module tb_pipelined_adder;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned SEG    = 4;
    localparam int          STAGES = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
    logic             sub       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int acc_count = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc;
        logic        lat;
    } exp_t;

    exp_t sb[$];

    pipelined_adder #(
        .WIDTH(WIDTH),
        .SEG  (SEG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [15:0] fa, input logic [15:0] fb,
                                   input logic fc, input logic fs);
        exp_t        r;
        logic [15:0] bb;
        logic        ci;
        logic [16:0] t;
        bb    = fs ? ~fb : fb;
        ci    = fs ? ~fc : fc;
        t     = {1'b0, fa} + {1'b0, bb} + {16'd0, ci};
        r.s   = t[15:0];
        r.c   = t[16];
        r.o   = (fa[15] == bb[15]) && (t[15] != fa[15]);
        r.acc = 0;
        r.lat = 1'b1;
        return r;
    endfunction

    // One clock: drive after the edge, settle, score outputs, log acceptance.
    task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic is, input logic ordy, input exp_t e);
        exp_t f;
        @(posedge clk);
        #1;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        sub       = is;
        out_ready = ordy;
        #1;
        cyc++;
        if (sb.size() == 0) begin
            check("no_spurious_valid", {31'd0, out_valid}, 32'd0);
        end else if (out_valid && out_ready) begin
            f = sb.pop_front();
            check("sum", {16'd0, sum}, {16'd0, f.s});
            check("cout", {31'd0, cout}, {31'd0, f.c});
            check("ovf", {31'd0, ovf}, {31'd0, f.o});
            if (f.lat) check("latency", cyc - f.acc, STAGES);
        end else if (out_valid) begin
            check("hold_sum", {16'd0, sum}, {16'd0, sb[0].s});
            check("hold_cout", {31'd0, cout}, {31'd0, sb[0].c});
        end
        if (in_valid && in_ready) begin
            e.acc = cyc;
            sb.push_back(e);
            acc_count++;
        end
    endtask

    task automatic idle(input logic ordy);
        exp_t z;
        z = '{s: 16'd0, c: 1'b0, o: 1'b0, acc: 0, lat: 1'b0};
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, ordy, z);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) idle(1'b1);
        check("drain_empty", sb.size(), 0);
    endtask

    vec_t vecs[12];

    initial begin
        exp_t e;
        int   target;
        int   guard;

        vecs[0]  = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3]  = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[5]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
        vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[10] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[11] = '{16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

        // Reset state.
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, one at a time, checking value and latency.
        for (int i = 0; i < 12; i++) begin
            e = '{s: vecs[i].es, c: vecs[i].ec, o: vecs[i].eo, acc: 0, lat: 1'b1};
            step(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b1, e);
            drain(10);
        end

        // 20 back-to-back beats, mixed add/sub; every result must show latency 4.
        for (int i = 0; i < 20; i++) begin
            logic [15:0] sa;
            logic [15:0] sbv;
            sa  = 16'(i * 32'h0F0F + 32'h0123);
            sbv = 16'(32'hFFFF - i * 32'h0111);
            step(1'b1, sa, sbv, i[0], i[1], 1'b1, model(sa, sbv, i[0], i[1]));
            if (i >= STAGES) check("in_ready_full_flow", {31'd0, in_ready}, 32'd1);
        end
        drain(10);

        // Fill the pipe under backpressure, stall, then release.
        target = acc_count + 5;
        guard  = 0;
        while (acc_count < target - 1 && guard < 20) begin
            logic [15:0] sa;
            sa = 16'h1000 + 16'(acc_count);
            e  = model(sa, 16'h0777, 1'b0, acc_count[0]);
            e.lat = 1'b0;
            step(1'b1, sa, 16'h0777, 1'b0, acc_count[0], 1'b0, e);
            guard++;
        end
        check("bp_fill_done", guard < 20 ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 6; i++) begin
            e = model(16'hABCD, 16'h1111, 1'b1, 1'b1);
            e.lat = 1'b0;
            step(1'b1, 16'hABCD, 16'h1111, 1'b1, 1'b1, 1'b0, e);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        guard = 0;
        while (acc_count < target && guard < 10) begin
            e = model(16'hABCD, 16'h1111, 1'b1, 1'b1);
            e.lat = 1'b0;
            step(1'b1, 16'hABCD, 16'h1111, 1'b1, 1'b1, 1'b1, e);
            guard++;
        end
        check("bp_release_accept", guard < 10 ? 32'd1 : 32'd0, 32'd1);
        drain(12);

        // Three beats in flight, then reset: nothing may survive it.
        for (int i = 0; i < 3; i++) begin
            e = model(16'h4000 + 16'(i), 16'h0100, 1'b0, 1'b0);
            e.lat = 1'b0;
            step(1'b1, 16'h4000 + 16'(i), 16'h0100, 1'b0, 1'b0, 1'b0, e);
        end
        guard = 0;
        while (!out_valid && guard < 8) begin
            idle(1'b0);
            guard++;
        end
        check("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_sum", {16'd0, sum}, 32'd0);
        check("mid_rst_cout", {31'd0, cout}, 32'd0);
        check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) idle(1'b1);

        // Recovery after reset.
        e = '{s: vecs[0].es, c: vecs[0].ec, o: vecs[0].eo, acc: 0, lat: 1'b1};
        step(1'b1, vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].sub, 1'b1, e);
        drain(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
